jpeg_sos_parser: RTL

//  Parametrised Start-of-Scan header parser. Consumes SOS payload bytes after the
//  0xFFDA marker (marker detector asserts start). Validates length and component

---
 rtl/jpeg_pkg.sv | 29 ++
 rtl/jpeg_sos_parser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG parser definitions.
//   M_SOS       : second byte of the Start-of-Scan marker (0xFFDA)
//   sos_state_t : SOS header parser state encoding
//   sos_err_t   : SOS header error codes reported on err_code
package jpeg_pkg;

    localparam logic [7:0] M_SOS = 8'hDA;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_H  = 4'd1,
        ST_LEN_L  = 4'd2,
        ST_NS     = 4'd3,
        ST_CS     = 4'd4,
        ST_TSEL   = 4'd5,
        ST_SS     = 4'd6,
        ST_SE     = 4'd7,
        ST_APPROX = 4'd8,
        ST_DRAIN  = 4'd9
    } sos_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_NS   = 2'd1,
        ERR_LEN  = 2'd2,
        ERR_SEL  = 2'd3
    } sos_err_t;

endpackage

// File: rtl/jpeg_sos_parser.sv
// Start-of-Scan header parser.
// Consumes the SOS segment payload (length bytes onward) after the marker
// detector pulses start. Validates Ls and Ns, checks the Huffman table
// selectors and latches per-component selections plus the progressive
// spectral / successive-approximation fields. A malformed header is reported
// on err/err_code and the remainder of the segment is drained so the upstream
// byte stream stays aligned to the next segment.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, abort           begin parse (ignored while busy) / drop current parse
//   in_valid/in_data/in_ready  byte stream, accepted on in_valid & in_ready
//   busy                   parser not idle
//   done, err              1-cycle result pulses; err_code holds until next start
//   ns, comp_id, dc_sel, ac_sel   scan component table, slot 0 in the LSBs
//   ss, se, ah, al         spectral selection and successive approximation
module jpeg_sos_parser
    import jpeg_pkg::*;
#(
    parameter int MAX_COMP = 4,
    parameter int NUM_HT   = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [2:0]                ns,
    output logic [8*MAX_COMP-1:0]     comp_id,
    output logic [SEL_W*MAX_COMP-1:0] dc_sel,
    output logic [SEL_W*MAX_COMP-1:0] ac_sel,
    output logic [7:0]                ss,
    output logic [7:0]                se,
    output logic [3:0]                ah,
    output logic [3:0]                al
);

    sos_state_t  state_reg;
    sos_err_t    err_code_reg;
    logic [15:0] ls_reg;
    logic [15:0] byte_cnt_reg;
    logic [2:0]  slot_reg;
    logic [2:0]  ns_reg;
    logic [7:0]  ss_reg;
    logic [7:0]  se_reg;
    logic [3:0]  ah_reg;
    logic [3:0]  al_reg;
    logic        done_reg;
    logic        err_reg;

    logic        accept;
    logic        clear_fields;
    logic [15:0] cnt_plus;
    logic [15:0] len_val;
    logic [15:0] exp_ls;
    logic [2:0]  slot_plus;
    logic        bad_ns;
    logic        bad_sel;
    sos_state_t  after_err;

    // in_ready is decoded from state only; abort masks it so the byte
    // presented alongside an abort stays with the upstream source.
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_LEN_H, ST_LEN_L, ST_NS, ST_CS, ST_TSEL,
            ST_SS, ST_SE, ST_APPROX, ST_DRAIN: in_ready = 1'b1;
            default:                           in_ready = 1'b0;
        endcase
        if (abort) begin
            in_ready = 1'b0;
        end
    end

    assign accept       = in_valid & in_ready;
    assign clear_fields = !abort && (state_reg == ST_IDLE) && start;
    assign cnt_plus     = byte_cnt_reg + 16'd1;
    assign len_val      = {ls_reg[15:8], in_data};
    assign exp_ls       = 16'd6 + {7'd0, in_data, 1'b0};
    assign slot_plus    = slot_reg + 3'd1;
    assign bad_ns       = (in_data == 8'd0) || (int'(in_data) > MAX_COMP);
    assign bad_sel      = (int'(in_data[7:4]) >= NUM_HT) || (int'(in_data[3:0]) >= NUM_HT);
    // If the offending byte was the last one of the segment there is nothing
    // left to drain.
    assign after_err    = (cnt_plus == ls_reg) ? ST_IDLE : ST_DRAIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            err_code_reg <= ERR_NONE;
            ls_reg       <= '0;
            byte_cnt_reg <= '0;
            slot_reg     <= '0;
            ns_reg       <= '0;
            ss_reg       <= '0;
            se_reg       <= '0;
            ah_reg       <= '0;
            al_reg       <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
            end else if (state_reg == ST_IDLE) begin
                if (start) begin
                    err_code_reg <= ERR_NONE;
                    ls_reg       <= '0;
                    byte_cnt_reg <= '0;
                    slot_reg     <= '0;
                    ns_reg       <= '0;
                    ss_reg       <= '0;
                    se_reg       <= '0;
                    ah_reg       <= '0;
                    al_reg       <= '0;
                    state_reg    <= ST_LEN_H;
                end
            end else if (accept) begin
                byte_cnt_reg <= cnt_plus;
                case (state_reg)
                    ST_LEN_H: begin
                        ls_reg    <= {in_data, 8'h00};
                        state_reg <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        ls_reg <= len_val;
                        if (len_val < 16'd8) begin
                            // Length is unusable, so no drain can be trusted.
                            err_reg      <= 1'b1;
                            err_code_reg <= ERR_LEN;
                            state_reg    <= ST_IDLE;
                        end else begin
                            state_reg <= ST_NS;
                        end
                    end
                    ST_NS: begin
                        if (bad_ns) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= ERR_NS;
                            state_reg    <= after_err;
                        end else begin
                            ns_reg   <= in_data[2:0];
                            slot_reg <= '0;
                            if (ls_reg != exp_ls) begin
                                err_reg      <= 1'b1;
                                err_code_reg <= ERR_LEN;
                                state_reg    <= after_err;
                            end else begin
                                state_reg <= ST_CS;
                            end
                        end
                    end
                    ST_CS: begin
                        state_reg <= ST_TSEL;
                    end
                    ST_TSEL: begin
                        if (bad_sel) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= ERR_SEL;
                            state_reg    <= after_err;
                        end else begin
                            slot_reg  <= slot_plus;
                            state_reg <= (slot_plus == ns_reg) ? ST_SS : ST_CS;
                        end
                    end
                    ST_SS: begin
                        ss_reg    <= in_data;
                        state_reg <= ST_SE;
                    end
                    ST_SE: begin
                        se_reg    <= in_data;
                        state_reg <= ST_APPROX;
                    end
                    ST_APPROX: begin
                        ah_reg    <= in_data[7:4];
                        al_reg    <= in_data[3:0];
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                    ST_DRAIN: begin
                        if (cnt_plus == ls_reg) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Per-slot component storage. A slot is written only while it is the
    // current slot index; the selector is stored truncated even when it is
    // out of range so the partial header remains observable.
    generate
        for (genvar gi = 0; gi < MAX_COMP; gi++) begin : g_slot
            logic             hit;
            logic             cs_we;
            logic             tsel_we;
            logic [7:0]       cid_reg;
            logic [SEL_W-1:0] dc_reg;
            logic [SEL_W-1:0] ac_reg;

            assign hit     = (slot_reg == 3'(gi));
            assign cs_we   = accept && (state_reg == ST_CS) && hit;
            assign tsel_we = accept && (state_reg == ST_TSEL) && hit;

            always_ff @(posedge clk) begin
                if (rst || clear_fields) begin
                    cid_reg <= '0;
                    dc_reg  <= '0;
                    ac_reg  <= '0;
                end else begin
                    if (cs_we) begin
                        cid_reg <= in_data;
                    end
                    if (tsel_we) begin
                        dc_reg <= in_data[4 +: SEL_W];
                        ac_reg <= in_data[0 +: SEL_W];
                    end
                end
            end

            assign comp_id[8*gi +: 8]        = cid_reg;
            assign dc_sel[SEL_W*gi +: SEL_W] = dc_reg;
            assign ac_sel[SEL_W*gi +: SEL_W] = ac_reg;
        end
    endgenerate

    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;
    assign ns       = ns_reg;
    assign ss       = ss_reg;
    assign se       = se_reg;
    assign ah       = ah_reg;
    assign al       = al_reg;

endmodule
